// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Byte-lane mask for an access of the given width at the given word offset.
  function automatic logic [3:0] be_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = 4'b0001;
      F3_H, F3_HU: m = 4'b0011;
      default:     m = 4'b1111;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store byte-enables/data replication and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_offset,
  input  logic [XLEN-1:0]   store_data,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_offset,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   load_val
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign be = be_mask(st_funct3, st_offset);

  always_comb begin
    wdata = store_data;
    case (st_funct3)
      F3_B, F3_BU: wdata = {4{store_data[7:0]}};
      F3_H, F3_HU: wdata = {2{store_data[15:0]}};
      default:     wdata = store_data;
    endcase
  end

  always_comb begin
    lane_b = rdata[7:0];
    case (ld_offset)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = ld_offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_val = rdata;
    case (ld_funct3)
      F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_val = {24'b0, lane_b};
      F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_val = {16'b0, lane_h};
      default: load_val = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one access per op over a req/ack bus, stalls until done.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic [XLEN-1:0]   load_data,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN/8-1:0] dbus_be,
  output logic [XLEN-1:0]   dbus_wdata,
  input  logic              dbus_ack,
  input  logic [XLEN-1:0]   dbus_rdata
);

  lsu_state_e        state;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              op;
  logic              illegal;
  logic [XLEN/8-1:0] al_be;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_load;

  assign op    = mem_read | mem_write;
  assign stall = (state == BUSY) | ((state == IDLE) & op);

  always_comb begin
    illegal = 1'b0;
    if (mem_read & mem_write) begin
      illegal = 1'b1;
    end else if (mem_read) begin
      illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end else begin
      illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    end
    if ((funct3 inside {F3_H, F3_HU}) && addr[0]) illegal = 1'b1;
    if ((funct3 == F3_W) && (addr[1:0] != 2'b00)) illegal = 1'b1;
  end

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .st_funct3 (funct3),
    .st_offset (addr[1:0]),
    .store_data(store_data),
    .be        (al_be),
    .wdata     (al_wdata),
    .ld_funct3 (f3_q),
    .ld_offset (off_q),
    .rdata     (dbus_rdata),
    .load_val  (al_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done       <= 1'b0;
      fault      <= 1'b0;
      load_data  <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (op) begin
            if (illegal) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state      <= BUSY;
              dbus_req   <= 1'b1;
              dbus_we    <= mem_write;
              dbus_addr  <= {addr[XLEN-1:2], 2'b00};
              dbus_be    <= al_be;
              dbus_wdata <= al_wdata;
              f3_q       <= funct3;
              off_q      <= addr[1:0];
            end
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            state     <= DONE;
            done      <= 1'b1;
            fault     <= 1'b0;
            dbus_req  <= 1'b0;
            load_data <= dbus_we ? '0 : al_load;
          end
        end
        DONE: begin
          // Inputs still show the finished op here, so they are not sampled.
          state <= IDLE;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a transaction-level expectation model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, fault;
  logic [31:0] load_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        chk_en = 1'b0;

  logic        exp_stall, exp_done, exp_fault, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;

  always #5 clk = ~clk;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .done(done), .fault(fault), .load_data(load_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Access size in bytes from the width code.
  function automatic int unsigned m_size(input logic [2:0] f3);
    int unsigned s;
    s = 1;
    for (int unsigned i = 0; i < 32'(f3[1:0]); i++) s = s * 2;
    return s;
  endfunction

  function automatic logic m_illegal(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    int unsigned v;
    v = 32'(f3);
    if (rd && wr) return 1'b1;
    if (rd && !(v == 0 || v == 1 || v == 2 || v == 4 || v == 5)) return 1'b1;
    if (wr && v > 2) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned mask;
    mask = (32'd1 << m_size(f3)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] r;
    case (m_size(f3))
      1: r = (sd & 32'hFF) * 32'h0101_0101;
      2: r = (sd & 32'hFFFF) * 32'h0001_0001;
      default: r = sd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int unsigned sz;
    sz = m_size(f3);
    v  = rd >> (8 * (a % 4));
    if (sz == 4) return rd;
    v = v & ((32'd1 << (8 * sz)) - 1);
    if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v | ~((32'd1 << (8 * sz)) - 1);
    return v;
  endfunction

  task automatic set_exp(input logic s, input logic d, input logic f, input logic q);
    exp_stall = s; exp_done = d; exp_fault = f; exp_req = q;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("done", 32'(done), 32'(exp_done));
      chk("fault", 32'(fault), 32'(exp_fault));
      chk("dbus_req", 32'(dbus_req), 32'(exp_req));
      chk("load_data", load_data, exp_ld);
      if (exp_req) begin
        chk("dbus_we", 32'(dbus_we), 32'(exp_we));
        chk("dbus_addr", dbus_addr, exp_addr);
        chk("dbus_be", 32'(dbus_be), 32'(exp_be));
        if (exp_we) chk("dbus_wdata", dbus_wdata, exp_wdata);
      end
    end
  end

  // One op: IDLE cycle, then fault DONE, or BUSY cycles with ack in the last, then DONE.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int unsigned dly, input logic [31:0] rdat);
    logic bad;
    bad = m_illegal(rd, wr, f3, a);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    dbus_ack = 1'b0; dbus_rdata = $urandom;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    if (!bad) begin
      for (int unsigned i = 0; i <= dly; i++) begin
        @(posedge clk); #1;
        dbus_ack   = (i == dly);
        dbus_rdata = (i == dly) ? rdat : $urandom;
        set_exp(1'b1, 1'b0, 1'b0, 1'b1);
        exp_we    = wr;
        exp_addr  = a & ~32'h3;
        exp_be    = m_be(f3, a);
        exp_wdata = m_wdata(f3, sd);
      end
    end
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = $urandom;
    set_exp(1'b0, 1'b1, bad, 1'b0);
    if (!bad) exp_ld = wr ? 32'h0 : m_load(f3, a, rdat);
  endtask

  task automatic idle(input int unsigned n, input logic stray);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; dbus_ack = stray; dbus_rdata = $urandom;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = '0; store_data = '0; dbus_ack = 1'b0; dbus_rdata = '0;
    exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_ld = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);

    // Hand-computed pins for the model itself.
    chk("pin_lb", m_load(3'd0, 32'h103, 32'h80FF_FFFF), 32'hFFFF_FF80);
    chk("pin_lbu", m_load(3'd4, 32'h103, 32'h80FF_FFFF), 32'h0000_0080);
    chk("pin_lh", m_load(3'd1, 32'h106, 32'h8001_7FFF), 32'hFFFF_8001);
    chk("pin_be_sh", 32'(m_be(3'd1, 32'h202)), 32'hC);
    chk("pin_wd_sh", m_wdata(3'd1, 32'h1234_ABCD), 32'hABCD_ABCD);
    chk("pin_ill_lw", 32'(m_illegal(1'b1, 1'b0, 3'd2, 32'h101)), 32'h1);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    idle(1, 1'b0);
    reset = 1'b0;
    idle(2, 1'b1);

    run_op(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 2, 32'hDEAD_BEEF);
    idle(1, 1'b0);
    run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
    run_op(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF_FFFF);
    idle(1, 1'b0);
    run_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 0, 32'h0);
    idle(1, 1'b0);
    run_op(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h0);
    run_op(1'b1, 1'b1, 3'd2, 32'h300, 32'h5, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'd3, 32'h300, 32'h0, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'd4, 32'h300, 32'h77, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'd1, 32'h201, 32'h77, 0, 32'h0);
    idle(1, 1'b1);
    run_op(1'b1, 1'b0, 3'd1, 32'h106, 32'h0, 1, 32'h8001_7FFF);
    run_op(1'b1, 1'b0, 3'd5, 32'h104, 32'h0, 0, 32'h8001_7FFF);
    run_op(1'b0, 1'b1, 3'd0, 32'h305, 32'h0000_00A5, 3, 32'h0);
    idle(2, 1'b0);

    // Back-to-back SW then LW.
    run_op(1'b0, 1'b1, 3'd2, 32'h400, 32'hCAFE_F00D, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 0, 32'h0102_0304);
    idle(2, 1'b0);

    // Reset while BUSY with the ack withheld.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h500;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_exp(1'b1, 1'b0, 1'b0, 1'b1);
      exp_we = 1'b0; exp_addr = 32'h500; exp_be = 4'hF;
    end
    @(posedge clk); #1;
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    exp_ld = 32'h0;
    idle(3, 1'b1);
    idle(2, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
